// File: rtl/gate_unit_arbiter.sv
// rtl/gate_unit_arbiter.sv - round-robin arbiter sharing one bitwise gate datapath among NREQ requesters
// Optional per-requester saturating grant counters on grant_cnt when GATE_ARB_STATS_EN is defined.
module gate_unit_arbiter #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
`ifdef GATE_ARB_STATS_EN
  ,
  parameter int CNTW  = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_in1,
  input  logic [WIDTH*NREQ-1:0]   req_in2,
  input  logic [NREQ-1:0]         req_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_data,
`ifdef GATE_ARB_STATS_EN
  output logic [CNTW*NREQ-1:0]    grant_cnt,
`endif
  output logic                    busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] OP_INV   = 2'b00;
  localparam logic [1:0] OP_AND2  = 2'b01;
  localparam logic [1:0] OP_NAND2 = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   id_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic             sel_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic             found;
  logic [IDW-1:0]   win;
  logic             accept;
  logic             rsp_fire;
  logic [WIDTH-1:0] result;
  int               idx;

  // Search starts just after the last served requester and wraps around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign accept   = rst_n && (state_q == S_IDLE) && found;
  assign rsp_fire = rsp_valid_q && rsp_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_comb begin
    case (op_q)
      OP_INV:   result = ~in1_q;
      OP_AND2:  result = in1_q & in2_q;
      OP_NAND2: result = ~(in1_q & in2_q);
      default:  result = sel_q ? in2_q : in1_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      op_q        <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      sel_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q  <= win;
        op_q  <= req_op[2*win +: 2];
        in1_q <= req_in1[WIDTH*win +: WIDTH];
        in2_q <= req_in2[WIDTH*win +: WIDTH];
        sel_q <= req_sel[win];
      end
      if (state_q == S_EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_data_q  <= result;
      end
      // rsp_id/rsp_data deliberately keep their values after the handshake.
      if ((state_q == S_RESP) && rsp_fire) begin
        rsp_valid_q <= 1'b0;
        last_q      <= id_q;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);

`ifdef GATE_ARB_STATS_EN
  logic [CNTW-1:0] cnt_q [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (accept && (cnt_q[win] != {CNTW{1'b1}})) begin
      cnt_q[win] <= cnt_q[win] + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[i*CNTW +: CNTW] = cnt_q[i];
  end
`endif

endmodule
